// File: rtl/spi_flash_responder_pkg.sv
// Shared opcodes, FSM encoding and status-register layout for the SPI flash responder.
// Command decode is a pure function so the FSM next-state logic stays readable.
package spi_flash_responder_pkg;

   localparam logic [7:0] CMD_WREN  = 8'h06;
   localparam logic [7:0] CMD_WRDI  = 8'h04;
   localparam logic [7:0] CMD_RDSR  = 8'h05;
   localparam logic [7:0] CMD_READ  = 8'h03;
   localparam logic [7:0] CMD_QREAD = 8'h6B;
   localparam logic [7:0] CMD_PROG  = 8'h02;

   localparam int SR_WIP = 0;
   localparam int SR_WEL = 1;

   typedef enum logic [2:0] {
      ST_IDLE, ST_CMD, ST_ADDR, ST_DUMMY, ST_RD_DATA, ST_PROG, ST_STATUS, ST_IGNORE
   } state_t;

   // A busy part only answers status polls; everything else is swallowed.
   function automatic state_t decode_cmd(input logic [7:0] op, input logic wel, input logic wip);
      state_t ns;
      ns = ST_IGNORE;
      if (!wip || op == CMD_RDSR) begin
         case (op)
            CMD_RDSR:            ns = ST_STATUS;
            CMD_READ, CMD_QREAD: ns = ST_ADDR;
            CMD_PROG:            ns = wel ? ST_ADDR : ST_IGNORE;
            default:             ns = ST_IGNORE;
         endcase
      end
      return ns;
   endfunction

endpackage

// File: rtl/spi_flash_mem.sv
// Byte array with one synchronous read port (1 clk) and one shared write port.
// The SPI program path wins over the backdoor if both strobe in the same clk.
module spi_flash_mem #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              fsm_we,
   input  logic [ADDR_W-1:0] fsm_addr,
   input  logic [7:0]        fsm_wdata,
   input  logic              bd_we,
   input  logic [ADDR_W-1:0] bd_addr,
   input  logic [7:0]        bd_wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [7:0]        rdata
);

   localparam int DEPTH = 2**ADDR_W;

   logic [7:0] mem [DEPTH];

   // No reset: contents must survive rst_n.
   always_ff @(posedge clk) begin
      if (fsm_we)
         mem[fsm_addr] <= fsm_wdata;
      else if (bd_we)
         mem[bd_addr] <= bd_wdata;
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/spi_flash_responder.sv
// SPI/QSPI flash target: oversamples sclk/cs_n, samples on sclk rise, drives on sclk fall.
// Serves READ/QUAD READ/PROGRAM/RDSR/WREN/WRDI from an internal array plus a backdoor load port.
module spi_flash_responder
   import spi_flash_responder_pkg::*;
#(
   parameter int ADDR_W      = 8,
   parameter int PROG_CYCLES = 64,
   parameter int DUMMY_CLKS  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sclk,
   input  logic              cs_n,
   input  logic [3:0]        io_in,
   output logic [3:0]        io_out,
   output logic [3:0]        io_oe,
   input  logic              bd_we,
   input  logic [ADDR_W-1:0] bd_addr,
   input  logic [7:0]        bd_wdata,
   output logic              wel,
   output logic              wip
);

   localparam int         PCW        = $clog2(PROG_CYCLES + 1);
   localparam logic [4:0] DUMMY_LAST = 5'(DUMMY_CLKS - 1);

   logic [1:0]        sclk_sync, cs_sync, din_sync;
   logic              sclk_d, cs_d;
   logic              rise, fall, cs_rise, cs_fall, din;
   state_t            state, state_nxt;
   logic [4:0]        bit_cnt;
   logic [7:0]        shreg, opcode, byte_in, rdata, status_byte;
   logic [ADDR_W-1:0] addr;
   logic [PCW-1:0]    prog_cnt;
   logic              prog_done, byte_done, quad, fsm_we, bd_ok;
   logic              unused_io;

   assign unused_io = &{1'b0, io_in[3:1]};

   // io_in[0] rides the same 2-flop delay as sclk so it is sampled as of the rise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_sync <= 2'b00;
         cs_sync   <= 2'b11;
         din_sync  <= 2'b00;
         sclk_d    <= 1'b0;
         cs_d      <= 1'b1;
      end else begin
         sclk_sync <= {sclk_sync[0], sclk};
         cs_sync   <= {cs_sync[0], cs_n};
         din_sync  <= {din_sync[0], io_in[0]};
         sclk_d    <= sclk_sync[1];
         cs_d      <= cs_sync[1];
      end
   end

   assign rise      = sclk_sync[1] & ~sclk_d;
   assign fall      = ~sclk_sync[1] & sclk_d;
   assign cs_rise   = cs_sync[1] & ~cs_d;
   assign cs_fall   = ~cs_sync[1] & cs_d;
   assign din       = din_sync[1];
   assign byte_in   = {shreg[6:0], din};
   assign byte_done = (bit_cnt == 5'd7);
   assign quad      = (opcode == CMD_QREAD);
   assign bd_ok     = bd_we & cs_sync[1] & ~wip;

   always_comb begin
      status_byte         = '0;
      status_byte[SR_WEL] = wel;
      status_byte[SR_WIP] = wip;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (cs_rise) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:  if (cs_fall) state_nxt = ST_CMD;
            ST_CMD:   if (rise && byte_done) state_nxt = decode_cmd(byte_in, wel, wip);
            ST_ADDR:  if (rise && bit_cnt == 5'd23)
                         state_nxt = quad ? ST_DUMMY : (opcode == CMD_PROG) ? ST_PROG : ST_RD_DATA;
            ST_DUMMY: if (rise && bit_cnt == DUMMY_LAST) state_nxt = ST_RD_DATA;
            default:  ;
         endcase
      end
   end

   always_comb begin
      io_oe  = 4'b0000;
      fsm_we = 1'b0;
      case (state)
         ST_RD_DATA: io_oe  = quad ? 4'b1111 : 4'b0010;
         ST_STATUS:  io_oe  = 4'b0010;
         ST_PROG:    fsm_we = rise && !cs_rise && byte_done;
         default:    ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt   <= '0;
         shreg     <= '0;
         opcode    <= '0;
         addr      <= '0;
         io_out    <= '0;
         wel       <= 1'b0;
         wip       <= 1'b0;
         prog_cnt  <= '0;
         prog_done <= 1'b0;
      end else begin
         if (wip) begin
            if (prog_cnt == '0) wip <= 1'b0;
            else                prog_cnt <= prog_cnt - PCW'(1);
         end
         if (cs_rise) begin
            bit_cnt   <= '0;
            io_out    <= '0;
            prog_done <= 1'b0;
            if (state == ST_PROG && prog_done) begin
               wel      <= 1'b0;
               wip      <= 1'b1;
               prog_cnt <= PCW'(PROG_CYCLES - 1);
            end
         end else if (rise) begin
            case (state)
               ST_CMD: begin
                  shreg <= byte_in;
                  if (byte_done) begin
                     bit_cnt <= '0;
                     opcode  <= byte_in;
                     if (!wip && byte_in == CMD_WREN) wel <= 1'b1;
                     if (!wip && byte_in == CMD_WRDI) wel <= 1'b0;
                  end else begin
                     bit_cnt <= bit_cnt + 5'd1;
                  end
               end
               ST_ADDR: begin
                  addr    <= {addr[ADDR_W-2:0], din};
                  bit_cnt <= (bit_cnt == 5'd23) ? '0 : bit_cnt + 5'd1;
               end
               ST_DUMMY: bit_cnt <= (bit_cnt == DUMMY_LAST) ? '0 : bit_cnt + 5'd1;
               ST_PROG: begin
                  shreg <= byte_in;
                  if (byte_done) begin
                     bit_cnt   <= '0;
                     addr      <= addr + ADDR_W'(1);
                     prog_done <= 1'b1;
                  end else begin
                     bit_cnt <= bit_cnt + 5'd1;
                  end
               end
               default: ;
            endcase
         end else if (fall) begin
            // rdata settles one clk after addr moves, well before the next fall.
            case (state)
               ST_RD_DATA: begin
                  if (quad) begin
                     io_out  <= bit_cnt[0] ? rdata[3:0] : rdata[7:4];
                     bit_cnt <= bit_cnt[0] ? 5'd0 : 5'd1;
                     if (bit_cnt[0]) addr <= addr + ADDR_W'(1);
                  end else begin
                     io_out  <= {2'b00, rdata[3'd7 - bit_cnt[2:0]], 1'b0};
                     bit_cnt <= byte_done ? '0 : bit_cnt + 5'd1;
                     if (byte_done) addr <= addr + ADDR_W'(1);
                  end
               end
               ST_STATUS: begin
                  io_out  <= {2'b00, status_byte[3'd7 - bit_cnt[2:0]], 1'b0};
                  bit_cnt <= byte_done ? '0 : bit_cnt + 5'd1;
               end
               default: ;
            endcase
         end
      end
   end

   spi_flash_mem #(.ADDR_W(ADDR_W)) mem (
      .clk      (clk),
      .fsm_we   (fsm_we),
      .fsm_addr (addr),
      .fsm_wdata(byte_in),
      .bd_we    (bd_ok),
      .bd_addr  (bd_addr),
      .bd_wdata (bd_wdata),
      .raddr    (addr),
      .rdata    (rdata)
   );

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: mode-0 SPI master with 4 clk per sclk phase.
module tb_spi_flash_responder;

   logic       clk = 1'b0;
   logic       rst_n, sclk, cs_n, bd_we, wel, wip;
   logic [3:0] io_in, io_out, io_oe;
   logic [7:0] bd_addr, bd_wdata;
   logic [3:0] smp_dat, smp_oe;
   int         total = 0;
   int         bad   = 0;
   int         oe_err;
   logic [7:0] rbuf [4];

   logic [7:0] pre_a [11] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'hFF, 8'h00, 8'h20, 8'h30, 8'h31, 8'h40, 8'h41};
   logic [7:0] pre_d [11] = '{8'hA5, 8'h5A, 8'hC3, 8'h3C, 8'h12, 8'h34, 8'h55, 8'h11, 8'h22, 8'hAA, 8'hBB};

   spi_flash_responder #(.ADDR_W(8), .PROG_CYCLES(64), .DUMMY_CLKS(8)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .sclk    (sclk),
      .cs_n    (cs_n),
      .io_in   (io_in),
      .io_out  (io_out),
      .io_oe   (io_oe),
      .bd_we   (bd_we),
      .bd_addr (bd_addr),
      .bd_wdata(bd_wdata),
      .wel     (wel),
      .wip     (wip)
   );

   always #5 clk = ~clk;

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: run did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic half();
      repeat (4) @(negedge clk);
   endtask

   // Present data in the low phase, sample DUT output just before the rise.
   task automatic xfer(input logic [3:0] d);
      io_in = d;
      half();
      smp_dat = io_out;
      smp_oe  = io_oe;
      sclk = 1'b1;
      half();
      sclk = 1'b0;
   endtask

   task automatic frame_start();
      cs_n = 1'b0;
      half();
   endtask

   task automatic frame_end();
      half();
      cs_n = 1'b1;
      half();
      half();
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) xfer({3'b000, b[i]});
   endtask

   task automatic send_addr(input logic [23:0] a);
      for (int i = 23; i >= 0; i--) xfer({3'b000, a[i]});
   endtask

   task automatic recv_byte(output logic [7:0] b);
      b = '0;
      for (int i = 0; i < 8; i++) begin
         xfer(4'b0000);
         b = {b[6:0], smp_dat[1]};
         if (smp_oe !== 4'b0010) oe_err++;
      end
   endtask

   task automatic bd_write(input logic [7:0] a, input logic [7:0] d);
      @(negedge clk);
      bd_addr = a; bd_wdata = d; bd_we = 1'b1;
      @(negedge clk);
      bd_we = 1'b0;
   endtask

   task automatic read_frame(input logic [23:0] a, input int n);
      logic [7:0] b;
      frame_start();
      send_byte(8'h03);
      chk("rd_cmd_oe", 32'(smp_oe), 32'h0);
      send_addr(a);
      oe_err = 0;
      for (int i = 0; i < n; i++) begin
         recv_byte(b);
         rbuf[i] = b;
      end
      chk("rd_data_oe", 32'(oe_err), 32'h0);
      frame_end();
      chk("rd_idle_oe", 32'(io_oe), 32'h0);
   endtask

   task automatic rdsr(output logic [7:0] s);
      frame_start();
      send_byte(8'h05);
      oe_err = 0;
      recv_byte(s);
      frame_end();
      chk("rdsr_oe", 32'(oe_err), 32'h0);
   endtask

   // Counts clk cycles with wip high; optionally holds a backdoor write for the whole window.
   task automatic measure_wip(input logic do_bd, output int n);
      int guard;
      guard = 0;
      n = 0;
      while (!wip && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (do_bd) begin
         bd_addr = 8'h30; bd_wdata = 8'hEE; bd_we = 1'b1;
      end
      while (wip && n < 200) begin
         @(negedge clk);
         n++;
      end
      bd_we = 1'b0;
   endtask

   initial begin : main
      logic [7:0] s;
      int         n;
      int         oe_seen;
      logic [7:0] dd;

      rst_n = 1'b0; sclk = 1'b0; cs_n = 1'b1; io_in = 4'h0;
      bd_we = 1'b0; bd_addr = 8'h00; bd_wdata = 8'h00;
      smp_dat = 4'h0; smp_oe = 4'h0; oe_err = 0;
      repeat (3) @(negedge clk);
      chk("rst_io_out", 32'(io_out), 32'h0);
      chk("rst_io_oe",  32'(io_oe),  32'h0);
      chk("rst_wel",    32'(wel),    32'h0);
      chk("rst_wip",    32'(wip),    32'h0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      for (int i = 0; i < 11; i++) bd_write(pre_a[i], pre_d[i]);

      // Single-line read of four backdoor-loaded bytes
      read_frame(24'h000010, 4);
      chk("rd10_b0", 32'(rbuf[0]), 32'hA5);
      chk("rd10_b1", 32'(rbuf[1]), 32'h5A);
      chk("rd10_b2", 32'(rbuf[2]), 32'hC3);
      chk("rd10_b3", 32'(rbuf[3]), 32'h3C);

      // Quad read across the top of memory: FF then wraps to 00
      frame_start();
      send_byte(8'h6B);
      send_addr(24'h0000FF);
      repeat (8) xfer(4'b0000);
      for (int i = 0; i < 4; i++) begin
         xfer(4'b0000);
         chk("qrd_nib", 32'(smp_dat), 32'(i + 1));
         chk("qrd_oe",  32'(smp_oe),  32'hF);
      end
      frame_end();
      chk("qrd_idle_oe", 32'(io_oe), 32'h0);

      // Program without WREN is dropped
      frame_start();
      send_byte(8'h02);
      send_addr(24'h000020);
      send_byte(8'h77);
      frame_end();
      chk("nowren_wip", 32'(wip), 32'h0);
      rdsr(s);
      chk("nowren_sr", 32'(s), 32'h00);
      read_frame(24'h000020, 1);
      chk("nowren_mem", 32'(rbuf[0]), 32'h55);

      // WREN then two-byte program; backdoor held during the busy window
      frame_start();
      send_byte(8'h06);
      frame_end();
      chk("wren_wel", 32'(wel), 32'h1);
      rdsr(s);
      chk("wren_sr", 32'(s), 32'h02);
      frame_start();
      send_byte(8'h02);
      send_addr(24'h000020);
      send_byte(8'h77);
      send_byte(8'h88);
      half();
      cs_n = 1'b1;
      measure_wip(1'b1, n);
      chk("prog_wip_len", 32'(n), 32'd64);
      chk("prog_wel", 32'(wel), 32'h0);
      repeat (8) @(negedge clk);
      rdsr(s);
      chk("prog_sr", 32'(s), 32'h00);
      read_frame(24'h000020, 2);
      chk("prog_b0", 32'(rbuf[0]), 32'h77);
      chk("prog_b1", 32'(rbuf[1]), 32'h88);
      read_frame(24'h000030, 1);
      chk("bd_blocked_wip", 32'(rbuf[0]), 32'h11);

      // Partial second byte is discarded, first byte still commits
      frame_start();
      send_byte(8'h06);
      frame_end();
      frame_start();
      send_byte(8'h02);
      send_addr(24'h000040);
      send_byte(8'hCC);
      dd = 8'hDD;
      for (int i = 7; i >= 3; i--) xfer({3'b000, dd[i]});
      half();
      cs_n = 1'b1;
      measure_wip(1'b0, n);
      chk("part_wip_len", 32'(n), 32'd64);
      chk("part_wel", 32'(wel), 32'h0);
      repeat (8) @(negedge clk);
      read_frame(24'h000040, 2);
      chk("part_b0", 32'(rbuf[0]), 32'hCC);
      chk("part_b1", 32'(rbuf[1]), 32'hBB);

      // Unknown opcode: outputs stay off; backdoor ignored while selected
      frame_start();
      send_byte(8'h9F);
      oe_seen = 0;
      for (int i = 0; i < 16; i++) begin
         xfer(4'b0000);
         if (smp_oe !== 4'b0000) oe_seen++;
         if (i == 4) bd_write(8'h31, 8'h99);
      end
      chk("unk_oe", 32'(oe_seen), 32'h0);
      frame_end();
      read_frame(24'h000030, 2);
      chk("unk_next_b0", 32'(rbuf[0]), 32'h11);
      chk("bd_blocked_cs", 32'(rbuf[1]), 32'h22);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
